// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: PC, imem handshake, next-PC selection
module ifu_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_3000,
    parameter int unsigned IMEM_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic [5:0]  o_op,
    output logic [5:0]  o_order_func,
    output logic        o_instr_valid,
    input  logic        i_instr_done,
    input  logic        i_beq,
    input  logic        i_j,
    input  logic        i_jal,
    input  logic        i_jr,
    input  logic        i_zero,
    input  logic [31:0] i_jr_target,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_fetch_err
);

    localparam int unsigned CW = $clog2(IMEM_TIMEOUT + 1);
    // Counter value seen in the last FETCH cycle allowed before giving up
    localparam logic [CW-1:0] C_LAST = CW'(IMEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t        r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_instr;
    logic          r_req;
    logic          r_valid;
    logic          r_err;
    logic [CW-1:0] r_cnt;

    logic [31:0]   w_pc_plus4;
    logic [31:0]   w_br_off;
    logic [31:0]   w_jump_tgt;
    logic [31:0]   w_next_pc;
    logic          w_jr_misaligned;

    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_br_off        = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_jump_tgt      = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    assign w_jr_misaligned = i_jr && (i_jr_target[1:0] != 2'b00);

    // Next-PC select: jr beats j/jal beats taken beq beats fall-through
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (i_jr) begin
            w_next_pc = {i_jr_target[31:2], 2'b00};
        end else if (i_j || i_jal) begin
            w_next_pc = w_jump_tgt;
        end else if (i_beq && i_zero) begin
            w_next_pc = w_pc_plus4 + w_br_off;
        end
    end

    // Fetch/execute sequencer; all handshake outputs are registered
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= 32'h0;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                    r_cnt   <= '0;
                end
                S_FETCH: begin
                    if (i_imem_ack) begin
                        r_instr <= i_imem_rdata;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= S_EXEC;
                    end else if (r_cnt == C_LAST) begin
                        r_cnt   <= r_cnt + CW'(1);
                        r_err   <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= S_HALT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_EXEC: begin
                    if (i_instr_done) begin
                        r_pc    <= w_next_pc;
                        r_valid <= 1'b0;
                        r_cnt   <= '0;
                        r_req   <= 1'b1;
                        r_state <= S_FETCH;
                        if (w_jr_misaligned) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    // HALT: frozen until reset
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_req    = r_req;
    assign o_imem_addr   = r_pc;
    assign o_instr       = r_instr;
    assign o_op          = r_instr[31:26];
    assign o_order_func  = r_instr[5:0];
    assign o_instr_valid = r_valid;
    assign o_pc          = r_pc;
    assign o_pc_plus4    = w_pc_plus4;
    assign o_fetch_err   = r_err;

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit directly upstream of the single-cycle controller.
- Holds the PC and fetches each word from instruction memory over a req/ack handshake.
- Presents the latched instruction, with its op and order_func fields, to the controller and datapath.
- When the datapath signals completion, computes the next PC from the controller's beq/j/jal/jr outputs plus the ALU zero flag.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IMEM_TIMEOUT, 16, maximum cycles to wait for imem_ack before flagging a fetch error.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  word address of the request, equal to pc.
- imem_ack  input  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  input  32  instruction word.
- instr  output  32  latched instruction.
- op  output  6  instr[31:26].
- order_func  output  6  instr[5:0].
- instr_valid  output  1  instr is held and executing.
- instr_done  input  1  datapath has finished the current instruction; commit the next PC.
- beq, j, jal, jr  input  1 each  controller decode outputs.
- zero  input  1  ALU equality result.
- jr_target  input  32  GPR[rs] value for jr.
- pc  output  32  address of the current instruction.
- pc_plus4  output  32  pc+4; link value for jal.
- fetch_err  output  1  sticky error flag: timeout or misaligned jr.

Behaviour:
- Reset, asynchronous while rst_n=0, outputs and state:
  - pc=RESET_PC; instr=0; instr_valid=0; imem_req=0; fetch_err=0; timeout counter=0; state=IDLE.
- States: IDLE, FETCH, EXEC, HALT.
- IDLE -> FETCH unconditionally on the first edge after reset release.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until the ack cycle.
  - On imem_ack=1: instr<=imem_rdata, instr_valid<=1, go EXEC. An ack in the first FETCH cycle is legal, giving 1-cycle fetch latency.
  - imem_ack while not in FETCH is ignored.
  - The counter increments each FETCH cycle without ack. When it reaches IMEM_TIMEOUT: fetch_err<=1, imem_req<=0, go HALT.
- EXEC:
  - instr_valid=1; instr, op and order_func stay constant; imem_req=0.
  - On instr_done=1: pc<=next_pc, instr_valid<=0, counter<=0, go FETCH.
  - instr_done outside EXEC is ignored.
- next_pc priority, highest first:
  - jr: {jr_target[31:2],2'b00}. If jr_target[1:0]!=0, also set fetch_err (execution continues).
  - j or jal: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - beq & zero: pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}.
  - otherwise: pc_plus4.
- Arithmetic:
  - All arithmetic is 32-bit modulo, so PC 32'hFFFF_FFFC + 4 = 0. No exception.
  - beq with zero=0 falls through to pc_plus4.
- pc_plus4 = pc+4, combinational and valid in every state.
- Simultaneous control inputs: the priority order above decides; no error is raised.
- HALT:
  - imem_req=0, instr_valid=0, pc frozen.
  - Exit only via reset.
- fetch_err is cleared only by reset.
- Reset mid-fetch or mid-exec: imem_req and instr_valid drop immediately (asynchronously). After release, fetch restarts at RESET_PC.

Test Plan:
- Reset then straight-line code, memory acks 2 cycles after req, instr_done 1 cycle after instr_valid -> imem_addr sequence 0x3000, 0x3004, 0x3008; req held stable while waiting.
- beq taken, instr=0x1000_FFFF at pc 0x3010, zero=1 -> next pc 0x3010. Same instruction with zero=0 -> 0x3014.
- j at pc 0x3000 with instr=0x0800_0C10 -> next pc 0x0000_3040. jal with the same target -> pc_plus4 reads 0x3004 during EXEC.
- jr=1 and j=1 together, jr_target=0x0000_3102 -> next pc 0x3100 and fetch_err=1.
- imem_ack never asserted -> after 16 FETCH cycles, fetch_err=1 and imem_req=0; state holds until rst_n pulse, then a fetch at 0x3000.
- rst_n asserted while imem_req=1 -> imem_req=0 in the same cycle. After release, pc=0x3000; an early instr_done during FETCH has no effect.
